hazard_forward_ctrl: RTL and testbench
======================================

// Module: hazard_forward_ctrl
// PURPOSE
//  Hazard and forwarding controller for the 5-stage MIPS pipeline. Keeps a shadow copy of the
//  destination/RegWrite/MemRead fields for the EX and MEM stages. Produces registered 2-bit
//  Forward codes (10=num_EX, 01=num_MEM, 00=bus) for the A/B operand forwarding muxes.
//  Sequences load-use stalls and branch flushes for PC, IF/ID and ID/EX, and counts lost cycles.
// PARAMETERS
//  REG_W  5   register-specifier width
//  CNT_W  16  width of the stall/flush performance counter (saturating)
// PORTS
//  clk            in   1      pipeline clock, all state updates on rising edge
//  rst            in   1      synchronous, active-high reset
//  id_rs          in   REG_W  rs specifier of the instruction in ID
//  id_rt          in   REG_W  rt specifier of the instruction in ID
//  id_use_rs      in   1      ID instruction reads rs
//  id_use_rt      in   1      ID instruction reads rt (includes store data)
//  id_dst         in   REG_W  destination register of the ID instruction (rd or rt already selected)
//  id_regwrite    in   1      ID instruction writes the register file
//  id_memread     in   1      ID instruction is a load
//  id_memwrite    in   1      ID instruction is a store
//  ex_branch_taken in  1      branch resolved taken in EX this cycle
//  forward_a      out  2      Forward code for operand A, valid while the instruction is in EX
//  forward_b      out  2      Forward code for operand B, valid while the instruction is in EX
//  ex_memwrite    out  1      store flag of the EX instruction (MemWrite to the B-mux)
//  pc_write       out  1      1 = PC may advance
//  ifid_write     out  1      1 = IF/ID may load
//  idex_bubble    out  1      1 = load a NOP (all control 0) into ID/EX
//  ifid_flush     out  1      1 = clear IF/ID
//  lost_cycles    out  CNT_W  count of stall+flush cycles since reset, saturates at all-ones
// BEHAVIOUR
//  Reset: forward_a/b=00, ex_memwrite=0, pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0,
//   lost_cycles=0, shadow EX/MEM entries invalid (regwrite=0, memread=0, dst=0), FSM=RUN.
//   Reset asserted mid-stall or mid-flush returns to RUN on the next edge; nothing pending survives.
//  Shadow pipe (every edge): MEM<=EX; EX<=ID fields, or a NOP entry when idex_bubble or ifid_flush=1.
//  Forwarding, computed from ID and registered on the same edge the instruction enters EX (latency 1):
//   src matches EX-shadow dst, EX regwrite=1, src!=0        -> 10
//   else src matches MEM-shadow dst, MEM regwrite=1, src!=0 -> 01
//   else 00. EX priority wins on double match. Unused operand (id_use_x=0) -> 00.
//   Register 0 is never forwarded. WB->ID is covered by register-file write-before-read.
//  ex_memwrite: registered copy of id_memwrite, forced 0 for bubble/flush entries.
//  Load-use: EX-shadow memread=1, regwrite=1, dst!=0, dst matches a used ID src -> hazard.
//  FSM states:
//   RUN:   hazard & !ex_branch_taken -> STALL. Outputs pc_write=0, ifid_write=0, idex_bubble=1
//          combinationally in this cycle. ex_branch_taken -> FLUSH. Outputs ifid_flush=1,
//          idex_bubble=1 this cycle; the flush wins over a simultaneous hazard.
//   STALL: exactly 1 cycle. The load is now in MEM, so the re-evaluated ID forwards 01 on that
//          operand. Return to RUN. A taken branch cannot occur here (EX holds a bubble).
//          If it is asserted anyway, it is treated as in RUN.
//   FLUSH: 1 cycle; fetch at the new PC proceeds -> RUN.
//  lost_cycles +1 on every cycle with idex_bubble=1; it holds at 2^CNT_W-1.
// STRUCTURE
//  Shared package: FWD_BUS=2'b00, FWD_MEM=2'b01, FWD_EX=2'b10; FSM state enum {RUN,STALL,FLUSH};
//   a NOP shadow-entry constant.
//  One sub-module, fwd_select: purely combinational src-vs-EX/MEM compare returning a 2-bit code.
//   It is instantiated twice (A, B). FSM, shadow pipe and counter stay in the top.
// TESTING
//  1 add $3,$1,$2 ; sub $4,$3,$5 -> sub in EX: forward_a=10, forward_b=00, no stall.
//  2 add $3 ; nop ; or $6,$3,$3 -> or in EX: forward_a=forward_b=01.
//  3 lw $3,0($1) ; add $4,$3,$2 -> 1 cycle pc_write=0, ifid_write=0, idex_bubble=1, then
//    add in EX with forward_a=01; lost_cycles=1.
//  4 add $3 ; sw $3,4($1) -> sw in EX: ex_memwrite=1, forward_b=10. Writes to $0 -> all codes 00.
//  5 lw-use hazard with the same-cycle ex_branch_taken=1 -> ifid_flush=1, idex_bubble=1,
//    pc_write=1, FSM FLUSH then RUN.
//  6 rst=1 during STALL -> next edge: all outputs at reset values; counter saturates at
//    all-ones with CNT_W=2 after 5 stalls.

Source files
------------

// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared types for the hazard/forwarding controller: forward codes,
// FSM states and the shadow-pipe entry carried through EX and MEM.
package hazard_forward_ctrl_pkg;

  localparam int REG_W_DEF = 5;

  localparam logic [1:0] FWD_BUS = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_EX  = 2'b10;

  typedef enum logic [1:0] {
    RUN,
    STALL,
    FLUSH
  } state_t;

  typedef struct packed {
    logic [REG_W_DEF-1:0] dst;
    logic                 regwrite;
    logic                 memread;
  } shadow_t;

  localparam shadow_t NOP_ENTRY = '{
    dst:      '0,
    regwrite: 1'b0,
    memread:  1'b0
  };

endpackage

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// Operand forward selector: compares one source specifier against the
// EX and MEM shadow entries and returns the forwarding mux code.
module fwd_select
  import hazard_forward_ctrl_pkg::*;
(
  input  logic [REG_W_DEF-1:0] src,
  input  logic                 use_src,
  input  shadow_t              ex,
  input  shadow_t              mem,
  output logic [1:0]           code
);

  logic live;
  logic ex_hit;
  logic mem_hit;

  assign live    = use_src && (src != '0);
  assign ex_hit  = live && ex.regwrite && (ex.dst == src);
  assign mem_hit = live && mem.regwrite && (mem.dst == src);

  // EX and MEM may both match; the younger result must win
  always_comb begin
    code = FWD_BUS;
    priority case (1'b1)
      ex_hit:  code = FWD_EX;
      mem_hit: code = FWD_MEM;
      default: code = FWD_BUS;
    endcase
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding controller: shadow EX/MEM fields, registered forward
// codes, load-use stall and branch flush, saturating lost-cycle counter.
module hazard_forward_ctrl
  import hazard_forward_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             ex_branch_taken,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             ex_memwrite,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic [CNT_W-1:0] lost_cycles
);

  state_t     state;
  state_t     state_d;
  shadow_t    ex_sh;
  shadow_t    mem_sh;
  shadow_t    id_sh;
  logic       ex_load;
  logic       hit_rs;
  logic       hit_rt;
  logic       hazard;
  logic [1:0] fa_d;
  logic [1:0] fb_d;

  assign id_sh = '{
    dst:      id_dst,
    regwrite: id_regwrite,
    memread:  id_memread
  };

  fwd_select u_fwd_a (
    .src     (id_rs),
    .use_src (id_use_rs),
    .ex      (ex_sh),
    .mem     (mem_sh),
    .code    (fa_d)
  );

  fwd_select u_fwd_b (
    .src     (id_rt),
    .use_src (id_use_rt),
    .ex      (ex_sh),
    .mem     (mem_sh),
    .code    (fb_d)
  );

  assign ex_load = ex_sh.memread && ex_sh.regwrite
                && (ex_sh.dst != '0);
  assign hit_rs  = id_use_rs && (id_rs == ex_sh.dst);
  assign hit_rt  = id_use_rt && (id_rt == ex_sh.dst);

  // STALL and FLUSH always last one cycle, so only RUN may start a stall
  assign hazard  = ex_load && (hit_rs || hit_rt)
                && (state == RUN);

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    state_d     = RUN;
    if (!rst) begin
      priority case (1'b1)
        ex_branch_taken: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          state_d     = FLUSH;
        end
        hazard: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          state_d     = STALL;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      ex_sh       <= NOP_ENTRY;
      mem_sh      <= NOP_ENTRY;
      forward_a   <= FWD_BUS;
      forward_b   <= FWD_BUS;
      ex_memwrite <= 1'b0;
      lost_cycles <= '0;
    end else begin
      state       <= state_d;
      mem_sh      <= ex_sh;
      ex_sh       <= idex_bubble ? NOP_ENTRY : id_sh;
      forward_a   <= idex_bubble ? FWD_BUS : fa_d;
      forward_b   <= idex_bubble ? FWD_BUS : fb_d;
      ex_memwrite <= id_memwrite && !idex_bubble;
      if (idex_bubble && (lost_cycles != {CNT_W{1'b1}}))
        lost_cycles <= lost_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: directed vector table, reset/saturation
// sequences, then random stimulus against a pipeline reference model.
module tb_hazard_forward_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, id_dst;
  logic       id_use_rs, id_use_rt;
  logic       id_regwrite, id_memread, id_memwrite;
  logic       ex_branch_taken;

  logic [1:0]  forward_a, forward_b;
  logic        ex_memwrite, pc_write, ifid_write;
  logic        idex_bubble, ifid_flush;
  logic [15:0] lost_cycles;

  logic [1:0]  s_fa, s_fb;
  logic        s_emw, s_pcw, s_ifw, s_bub, s_fl;
  logic [1:0]  s_lost;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_forward_ctrl u_dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_use_rs       (id_use_rs),
    .id_use_rt       (id_use_rt),
    .id_dst          (id_dst),
    .id_regwrite     (id_regwrite),
    .id_memread      (id_memread),
    .id_memwrite     (id_memwrite),
    .ex_branch_taken (ex_branch_taken),
    .forward_a       (forward_a),
    .forward_b       (forward_b),
    .ex_memwrite     (ex_memwrite),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .idex_bubble     (idex_bubble),
    .ifid_flush      (ifid_flush),
    .lost_cycles     (lost_cycles)
  );

  hazard_forward_ctrl #(.CNT_W(2)) u_sat (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_use_rs       (id_use_rs),
    .id_use_rt       (id_use_rt),
    .id_dst          (id_dst),
    .id_regwrite     (id_regwrite),
    .id_memread      (id_memread),
    .id_memwrite     (id_memwrite),
    .ex_branch_taken (ex_branch_taken),
    .forward_a       (s_fa),
    .forward_b       (s_fb),
    .ex_memwrite     (s_emw),
    .pc_write        (s_pcw),
    .ifid_write      (s_ifw),
    .idex_bubble     (s_bub),
    .ifid_flush      (s_fl),
    .lost_cycles     (s_lost)
  );

  typedef struct {
    logic [4:0] rs, rt, dst;
    logic       urs, urt, rw, mr, mw, br;
    logic [1:0] fa, fb;
    logic       emw, pcw, bub, fl;
    int         lost;
  } vec_t;

  vec_t tbl[$];

  typedef struct {
    int dst;
    bit wr;
    bit ld;
  } ent_t;

  ent_t pipe[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] fa,
                         input logic [1:0] fb, input logic emw,
                         input logic pcw, input logic bub,
                         input logic fl, input int lost);
    int sl;
    sl = (lost > 3) ? 3 : lost;
    chk({tag, ".fa"},   32'(forward_a),   32'(fa));
    chk({tag, ".fb"},   32'(forward_b),   32'(fb));
    chk({tag, ".emw"},  32'(ex_memwrite), 32'(emw));
    chk({tag, ".pcw"},  32'(pc_write),    32'(pcw));
    chk({tag, ".ifw"},  32'(ifid_write),  32'(pcw));
    chk({tag, ".bub"},  32'(idex_bubble), 32'(bub));
    chk({tag, ".fl"},   32'(ifid_flush),  32'(fl));
    chk({tag, ".lost"}, 32'(lost_cycles), 32'(lost));
    chk({tag, ".sfa"},  32'(s_fa),        32'(fa));
    chk({tag, ".sbub"}, 32'(s_bub),       32'(bub));
    chk({tag, ".slost"}, 32'(s_lost),     32'(sl));
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt,
                       input logic [4:0] dst, input logic rw,
                       input logic mr, input logic mw, input logic br);
    id_rs = rs; id_rt = rt;
    id_use_rs = urs; id_use_rt = urt;
    id_dst = dst; id_regwrite = rw;
    id_memread = mr; id_memwrite = mw;
    ex_branch_taken = br;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic row(input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt,
                     input logic [4:0] dst, input logic rw,
                     input logic mr, input logic mw, input logic br,
                     input logic [1:0] fa, input logic [1:0] fb,
                     input logic emw, input logic pcw,
                     input logic bub, input logic fl, input int lost);
    vec_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
    v.dst = dst; v.rw = rw; v.mr = mr; v.mw = mw; v.br = br;
    v.fa = fa; v.fb = fb; v.emw = emw; v.pcw = pcw;
    v.bub = bub; v.fl = fl; v.lost = lost;
    tbl.push_back(v);
  endtask

  function automatic logic [1:0] mfwd(int src, bit use_it);
    if (!use_it || src == 0) return 2'b00;
    if (pipe[0].wr && pipe[0].dst == src) return 2'b10;
    if (pipe[1].wr && pipe[1].dst == src) return 2'b01;
    return 2'b00;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] efa, efb;
    logic       eemw;
    int         elost;
    logic       haz, bub, pcw;
    ent_t       e;

    // add/sub EX forward
    row(1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    row(3, 5, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1, 0, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    // add ; nop ; or -> MEM forward both
    row(1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    row(3, 3, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    // lw ; add -> one stall then MEM forward
    row(1, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    row(3, 2, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    row(3, 2, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    // add ; sw -> store data forward, then $0 writes
    row(1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    row(1, 3, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0, 1);
    row(1, 2, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    row(0, 0, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    // lw-use with taken branch -> flush wins
    row(1, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    row(3, 2, 1, 1, 4, 1, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2);

    rst = 1'b1;
    nop();
    tick();
    tick();
    @(negedge clk);
    chk_all("reset", 0, 0, 0, 1, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt,
            tbl[i].dst, tbl[i].rw, tbl[i].mr, tbl[i].mw, tbl[i].br);
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), tbl[i].fa, tbl[i].fb,
              tbl[i].emw, tbl[i].pcw, tbl[i].bub, tbl[i].fl,
              tbl[i].lost);
      tick();
    end

    // reset while stalled: nothing survives
    drive(1, 0, 1, 0, 3, 1, 1, 0, 0);
    tick();
    drive(3, 2, 1, 1, 4, 1, 0, 0, 0);
    @(negedge clk);
    chk("rststall.pre", 32'(pc_write), 32'd0);
    rst = 1'b1;
    tick();
    chk_all("rststall.rst", 0, 0, 0, 1, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    chk_all("rststall.run", 0, 0, 0, 1, 0, 0, 0);
    tick();

    // five stalls: 2-bit counter pins at 3
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 1, 0, 3, 1, 1, 0, 0);
      tick();
      drive(0, 3, 0, 1, 4, 1, 0, 0, 0);
      tick();
      tick();
      nop();
      @(negedge clk);
      chk($sformatf("sat%0d.lost", k), 32'(lost_cycles), 32'(k + 1));
      chk($sformatf("sat%0d.slost", k), 32'(s_lost),
          32'((k + 1 > 3) ? 3 : k + 1));
      tick();
    end

    // randomized against reference model
    rst = 1'b1;
    nop();
    tick();
    rst = 1'b0;
    pipe.delete();
    e.dst = 0; e.wr = 0; e.ld = 0;
    pipe.push_back(e);
    pipe.push_back(e);
    efa = 0; efb = 0; eemw = 0; elost = 0;
    for (int n = 0; n < 600; n++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom_range(0, 7) == 0));
      haz = pipe[0].ld && pipe[0].wr && pipe[0].dst != 0 &&
            ((id_use_rs && int'(id_rs) == pipe[0].dst) ||
             (id_use_rt && int'(id_rt) == pipe[0].dst));
      bub = haz || ex_branch_taken;
      pcw = !(haz && !ex_branch_taken);
      @(negedge clk);
      chk_all($sformatf("rnd%0d", n), efa, efb, eemw, pcw, bub,
              ex_branch_taken, elost);
      if (bub) begin
        e.dst = 0; e.wr = 0; e.ld = 0;
        efa = 0; efb = 0; eemw = 0;
        if (elost < 65535) elost++;
      end else begin
        e.dst = int'(id_dst); e.wr = id_regwrite; e.ld = id_memread;
        efa = mfwd(int'(id_rs), id_use_rs);
        efb = mfwd(int'(id_rt), id_use_rt);
        eemw = id_memwrite;
      end
      pipe.push_front(e);
      void'(pipe.pop_back());
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
